// File: rtl/imm_gen_pipe.sv
// RV immediate generator: decodes one instruction per cycle into a sign-extended
// immediate and format code, buffered in a 2-entry skid FIFO with an illegal counter.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      INSTR,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  IMM,
  output logic [2:0]       FMT,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] ILL_CNT
);

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ILL   = 3'd7;

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_p0;
  logic [2:0]      fmt_p0;

  assign opcode = INSTR[6:0];
  assign funct3 = INSTR[14:12];

  // ---- stage p0: combinational decode of the incoming word ----
  always_comb begin
    imm_p0 = '0;
    fmt_p0 = FMT_ILL;
    case (opcode)
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt_p0 = FMT_SHAMT;
          if (XLEN == 64) imm_p0 = XLEN'({26'd0, INSTR[25:20]});
          else            imm_p0 = XLEN'({27'd0, INSTR[24:20]});
        end else begin
          fmt_p0 = FMT_I;
          imm_p0 = sext32({{20{INSTR[31]}}, INSTR[31:20]});
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt_p0 = FMT_I;
        imm_p0 = sext32({{20{INSTR[31]}}, INSTR[31:20]});
      end
      7'b0100011: begin
        fmt_p0 = FMT_S;
        imm_p0 = sext32({{20{INSTR[31]}}, INSTR[31:25], INSTR[11:7]});
      end
      7'b1100011: begin
        fmt_p0 = FMT_B;
        imm_p0 = sext32({{19{INSTR[31]}}, INSTR[31], INSTR[7], INSTR[30:25],
                         INSTR[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        fmt_p0 = FMT_U;
        imm_p0 = sext32({INSTR[31:12], 12'b0});
      end
      7'b1101111: begin
        fmt_p0 = FMT_J;
        imm_p0 = sext32({{11{INSTR[31]}}, INSTR[31], INSTR[19:12], INSTR[20],
                         INSTR[30:21], 1'b0});
      end
      7'b0110011, 7'b0111011: begin
        fmt_p0 = FMT_R;
        imm_p0 = '0;
      end
      default: begin
        fmt_p0 = FMT_ILL;
        imm_p0 = '0;
      end
    endcase
  end

  logic [XLEN-1:0]  imm_p1 [2];
  logic [2:0]       fmt_p1 [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;
  logic             vld_p1;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] ill_cnt;

  // in_ready depends only on registered occupancy, never on out_ready
  assign in_ready = (occ != 2'd2);
  assign vld_p1   = (occ != 2'd0);
  assign push     = in_valid & in_ready;
  assign pop      = vld_p1 & out_ready;

  // ---- stage p1: 2-entry skid buffer ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ     <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      ill_cnt <= '0;
    end else begin
      occ <= occ + 2'(push) - 2'(pop);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && fmt_p0 == FMT_ILL) ill_cnt <= sat_inc(ill_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      imm_p1[wr_ptr] <= imm_p0;
      fmt_p1[wr_ptr] <= fmt_p0;
    end
  end

  // Head is forced to zero while empty, so reset clears outputs without a clock.
  assign out_valid = vld_p1;
  assign IMM       = vld_p1 ? imm_p1[rd_ptr] : '0;
  assign FMT       = vld_p1 ? fmt_p1[rd_ptr] : 3'd0;
  assign ILLEGAL   = vld_p1 && (fmt_p1[rd_ptr] == FMT_ILL);
  assign ILL_CNT   = ill_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: directed vectors plus randomized traffic, checked
// through a scoreboard fed by a spec-level decode model.
module tb_imm_gen_pipe;
  localparam int XLEN  = 64;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      INSTR;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  IMM;
  logic [2:0]       FMT;
  logic             ILLEGAL;
  logic [CNT_W-1:0] ILL_CNT;

  imm_gen_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .INSTR(INSTR), .out_valid(out_valid), .out_ready(out_ready), .IMM(IMM),
    .FMT(FMT), .ILLEGAL(ILLEGAL), .ILL_CNT(ILL_CNT)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f;
    logic [63:0] m;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          model_ill = 0;
  logic        held = 1'b0;
  logic [63:0] held_imm;
  logic [2:0]  held_fmt;
  logic [6:0]  ops [12] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
                            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                            7'b1101111, 7'b0110011, 7'b0111011, 7'b0010011};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: field value read as a two's-complement number of the given width.
  function automatic longint as_signed(input longint raw, input int bits);
    if (raw >= (longint'(1) << (bits - 1))) return raw - (longint'(1) << bits);
    return raw;
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t   e;
    longint v;
    e.f = 3'd7;
    v   = 0;
    case (i[6:0])
      7'b0010011: begin
        if (i[14:12] == 3'b001 || i[14:12] == 3'b101) begin
          e.f = 3'd6; v = longint'(i[25:20]);
        end else begin
          e.f = 3'd1; v = as_signed(longint'(i[31:20]), 12);
        end
      end
      7'b0000011, 7'b1100111, 7'b1110011: begin
        e.f = 3'd1; v = as_signed(longint'(i[31:20]), 12);
      end
      7'b0100011: begin
        e.f = 3'd2;
        v = as_signed(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
      end
      7'b1100011: begin
        e.f = 3'd3;
        v = as_signed(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
                      longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
      end
      7'b0110111, 7'b0010111: begin
        e.f = 3'd4; v = as_signed(longint'(i[31:12]) * 4096, 32);
      end
      7'b1101111: begin
        e.f = 3'd5;
        v = as_signed(longint'(i[31]) * (1 << 20) + longint'(i[19:12]) * 4096 +
                      longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
      end
      7'b0110011, 7'b0111011: begin
        e.f = 3'd0; v = 0;
      end
      default: begin
        e.f = 3'd7; v = 0;
      end
    endcase
    e.m = 64'(v);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 13);
    if (k < 12) r[6:0] = ops[k];
    return r;
  endfunction

  // Monitor: samples on the falling edge, mirrors occupancy with the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      sb.delete();
      model_ill = 0;
      held = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
      chk("ill_cnt", 64'(ILL_CNT), 64'(model_ill));
      if (held) begin
        chk("hold_imm", IMM, held_imm);
        chk("hold_fmt", 64'(FMT), 64'(held_fmt));
      end
      if (!out_valid) begin
        chk("idle_zero", IMM | 64'(FMT) | 64'(ILLEGAL), 64'd0);
      end else if (out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("fmt", 64'(FMT), 64'(e.f));
        chk("imm", IMM, e.m);
        chk("illegal", 64'(ILLEGAL), 64'(e.f == 3'd7));
      end
      held     = out_valid && !out_ready;
      held_imm = IMM;
      held_fmt = FMT;
      if (in_valid && in_ready) begin
        e = ref_dec(INSTR);
        sb.push_back(e);
        if (e.f == 3'd7 && model_ill < CMAX) model_ill++;
      end
    end
  end

  task automatic send(input logic [31:0] ins);
    int g;
    g = 0;
    in_valid = 1'b1;
    INSTR    = ins;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_chk(input logic [31:0] ins, input logic [2:0] ef, input logic [63:0] ei);
    @(posedge clk); #1;
    in_valid = 1'b1;
    INSTR    = ins;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("dir_vld", 64'(out_valid), 64'd1);
    chk("dir_fmt", 64'(FMT), 64'(ef));
    chk("dir_imm", IMM, ei);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: entries left got %0d expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: sim time got %0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    INSTR     = '0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ill_cnt", 64'(ILL_CNT), 64'd0);
    chk("rst_imm_fmt", IMM | 64'(FMT) | 64'(ILLEGAL), 64'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    push_chk(32'hFFF00093, 3'd1, 64'hFFFFFFFFFFFFFFFF);
    push_chk(32'hFE000EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC);
    push_chk(32'h800000B7, 3'd4, 64'hFFFFFFFF80000000);
    push_chk(32'h03F09093, 3'd6, 64'h000000000000003F);
    push_chk(32'h00000033, 3'd0, 64'h0);
    drain();

    out_ready = 1'b0;
    send(32'h00500113);
    send(32'h123450B7);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    fork
      send(32'hFE000EE3);
      begin
        repeat (2) @(posedge clk);
        #2;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_head", IMM, 64'd5);
        @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();

    for (int k = 0; k < 300; k++) send(32'h0000007F);
    drain();
    chk("ill_sat", 64'(ILL_CNT), 64'(CMAX));

    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      INSTR     = rand_instr();
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    send(32'h0000007F);
    send(32'h00000013);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ill", 64'(ILL_CNT), 64'd0);
    chk("mid_rst_zero", IMM | 64'(FMT) | 64'(ILLEGAL), 64'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_idle", 64'(out_valid), 64'd0);
    end
    push_chk(32'h03F09093, 3'd6, 64'h3F);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
